cskip_sub_serial: RTL and testbench
===================================

// Module: cskip_sub_serial
// PURPOSE
//  Group-serial carry-skip subtractor: o_diff = i_minuend - i_subtrahend (two's complement, a + ~b + 1).
//  Processes one 4-bit group per clock with per-group skip logic; valid/ready handshake on both sides.
//  Inverse-operation companion to the combinational CSkipA adders; used where area beats latency.
// PARAMETERS
//  WIDTH   12  operand/result width; must be a multiple of 4 (elaboration error otherwise)
//  NGROUPS derived = WIDTH/4, not user-set
// PORTS
//  i_clk          in   1      clock, all state on rising edge
//  i_rst_n        in   1      asynchronous active-low reset
//  i_valid        in   1      operands valid
//  o_ready        out  1      block can accept operands (high only in IDLE)
//  i_minuend      in   WIDTH  operand a
//  i_subtrahend   in   WIDTH  operand b
//  o_valid        out  1      result valid (high only in DONE)
//  i_ready        in   1      downstream accepts result
//  o_diff         out  WIDTH  a - b mod 2^WIDTH
//  o_borrow       out  1      1 when a < b unsigned (= ~carry-out of a + ~b + 1)
//  o_overflow     out  1      signed overflow; only with CSKIPS_OVERFLOW_EN
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE, o_valid=0, o_diff=0, o_borrow=0, o_overflow=0, group idx=0, carry=1.
//  Reset mid-operation aborts the op immediately; no result produced; o_ready=1 once in IDLE.
//  FSM IDLE -> CALC -> DONE -> IDLE:
//   IDLE: o_ready=1; on i_valid&&o_ready latch a, ~b; idx=0; carry=1; go CALC.
//   CALC: each cycle compute group idx: s = a_g + nb_g + carry (4-bit ripple);
//         P = &(a_g ^ nb_g); carry_next = P ? carry : ripple_cout; write o_diff slice idx.
//         idx==NGROUPS-1 -> set o_borrow=~carry_next, go DONE; else idx++.
//   DONE: o_valid=1; o_diff/o_borrow/o_overflow held stable until i_ready; on i_ready go IDLE.
//  Latency: o_valid rises NGROUPS edges after the accept edge (3 for WIDTH=12).
//  Throughput: one op per NGROUPS+2 cycles min; no accept in DONE (o_ready=0), no pass-through.
//  i_valid and operand changes while not in IDLE are ignored.
//  o_diff slices of an in-progress op are not meaningful until o_valid; bench samples only at o_valid.
//  Skip path must be functionally identical to pure ripple; it exists for timing only.
// CONFIGURATION
//  CSKIPS_OVERFLOW_EN defined: o_overflow port present; set at DONE entry to
//   (a[W-1] != b[W-1]) && (o_diff[W-1] != a[W-1]); reset 0; held with o_diff.
//  Undefined: no o_overflow port, no overflow logic.
// STRUCTURE
//  Package cskip_pkg: CSKIP_GROUP_W=4; state enum cskip_state_t {IDLE, CALC, DONE}.
//  Sub-module cskip4_sub_stage: combinational 4-bit ripple + skip mux
//   (a_g, nb_g, cin) -> (s_g, cout); instanced once, time-multiplexed over groups.
//  Top: FSM, idx counter ($clog2(NGROUPS) bits), carry reg, operand regs, result reg.
// TESTING
//  1) a=12'h005, b=12'h003 -> o_diff=12'h002, o_borrow=0, o_valid exactly 3 cycles after accept.
//  2) a=12'h000, b=12'h001 -> o_diff=12'hFFF, o_borrow=1 (borrow through all groups).
//  3) a=b=12'hABC -> o_diff=12'h000, o_borrow=0; every group takes skip path (P=1).
//  4) DONE with i_ready low 5 cycles -> o_diff/o_valid stable, o_ready=0, new i_valid ignored.
//  5) i_rst_n low during CALC idx=1 -> o_valid=0, o_diff=0 at once; then a=12'h800,b=12'h001
//     -> 12'h7FF, o_borrow=0, o_overflow=1 (macro on).
//  6) 1000 random ops with random i_valid/i_ready -> match model (a-b, a<b) with no lost/dup results.

Source files
------------

// File: rtl/cskip_pkg.sv
// Shared definitions for the group-serial carry-skip subtractor.
package cskip_pkg;

   localparam int CSKIP_GROUP_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } cskip_state_t;

endpackage

// File: rtl/cskip4_sub_stage.sv
// One 4-bit group of a + ~b + cin: ripple adder with a carry-skip mux on the group propagate.
module cskip4_sub_stage
   import cskip_pkg::*;
(
   input  logic [CSKIP_GROUP_W-1:0] a_g,
   input  logic [CSKIP_GROUP_W-1:0] nb_g,
   input  logic                     cin,
   output logic [CSKIP_GROUP_W-1:0] s_g,
   output logic                     cout
);

   logic [CSKIP_GROUP_W:0] c;
   logic                   prop;

   always_comb begin
      c    = '0;
      s_g  = '0;
      c[0] = cin;
      for (int i = 0; i < CSKIP_GROUP_W; i++) begin
         s_g[i]   = a_g[i] ^ nb_g[i] ^ c[i];
         c[i+1]   = (a_g[i] & nb_g[i]) | (c[i] & (a_g[i] ^ nb_g[i]));
      end
   end

   // When every bit propagates, the group carry-out equals cin; the mux shortens that path.
   assign prop = &(a_g ^ nb_g);
   assign cout = prop ? cin : c[CSKIP_GROUP_W];

endmodule

// File: rtl/cskip_sub_serial.sv
// Group-serial carry-skip subtractor, one 4-bit group per clock with valid/ready on both sides.
// Define CSKIPS_OVERFLOW_EN to add the o_overflow (signed overflow) output.
module cskip_sub_serial
   import cskip_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_minuend,
   input  logic [WIDTH-1:0] i_subtrahend,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_diff,
`ifdef CSKIPS_OVERFLOW_EN
   output logic             o_borrow,
   output logic             o_overflow
`else
   output logic             o_borrow
`endif
);

   localparam int NGROUPS = WIDTH / CSKIP_GROUP_W;
   localparam int IDX_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NGROUPS - 1);

   generate
      if ((WIDTH % CSKIP_GROUP_W) != 0 || WIDTH == 0) begin : g_bad_width
         $error("cskip_sub_serial: WIDTH must be a non-zero multiple of 4");
      end
   endgenerate

   cskip_state_t             state, state_next;
   logic [IDX_W-1:0]         idx;
   logic                     carry;
   logic [WIDTH-1:0]         a_reg;
   logic [WIDTH-1:0]         nb_reg;
   logic [WIDTH-1:0]         diff_reg;
   logic                     borrow_reg;
   logic [CSKIP_GROUP_W-1:0] a_g;
   logic [CSKIP_GROUP_W-1:0] nb_g;
   logic [CSKIP_GROUP_W-1:0] s_g;
   logic                     cout_g;

   always_comb begin
      a_g  = '0;
      nb_g = '0;
      for (int g = 0; g < NGROUPS; g++) begin
         if (idx == IDX_W'(g)) begin
            a_g  = a_reg[g*CSKIP_GROUP_W +: CSKIP_GROUP_W];
            nb_g = nb_reg[g*CSKIP_GROUP_W +: CSKIP_GROUP_W];
         end
      end
   end

   cskip4_sub_stage u_stage (
      .a_g  (a_g),
      .nb_g (nb_g),
      .cin  (carry),
      .s_g  (s_g),
      .cout (cout_g)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_valid)          state_next = CALC;
         CALC:    if (idx == LAST_IDX)  state_next = DONE;
         DONE:    if (i_ready)          state_next = IDLE;
         default:                       state_next = IDLE;
      endcase
   end

   assign o_ready = (state == IDLE);
   assign o_valid = (state == DONE);

`ifdef CSKIPS_OVERFLOW_EN
   logic ovf_reg;
   assign o_overflow = ovf_reg;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx        <= '0;
         carry      <= 1'b1;
         a_reg      <= '0;
         nb_reg     <= '0;
         diff_reg   <= '0;
         borrow_reg <= 1'b0;
`ifdef CSKIPS_OVERFLOW_EN
         ovf_reg    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  a_reg  <= i_minuend;
                  nb_reg <= ~i_subtrahend;
                  idx    <= '0;
                  carry  <= 1'b1;
               end
            end
            CALC: begin
               carry <= cout_g;
               for (int g = 0; g < NGROUPS; g++) begin
                  if (idx == IDX_W'(g)) begin
                     diff_reg[g*CSKIP_GROUP_W +: CSKIP_GROUP_W] <= s_g;
                  end
               end
               if (idx == LAST_IDX) begin
                  borrow_reg <= ~cout_g;
`ifdef CSKIPS_OVERFLOW_EN
                  // Operand signs differ exactly when a and ~b share a sign bit.
                  ovf_reg <= (a_reg[WIDTH-1] == nb_reg[WIDTH-1]) &&
                             (s_g[CSKIP_GROUP_W-1] != a_reg[WIDTH-1]);
`endif
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_diff   = diff_reg;
   assign o_borrow = borrow_reg;

endmodule

// File: tb/tb_cskip_sub_serial.sv
// Directed table and corner-sequence bench for cskip_sub_serial (WIDTH=12).
module tb_cskip_sub_serial;

   localparam int W = 12;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_valid = 1'b0;
   logic         i_ready = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         o_ready;
   logic         o_valid;
   logic [W-1:0] o_diff;
   logic         o_borrow;
`ifdef CSKIPS_OVERFLOW_EN
   logic         o_overflow;
`endif

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   cskip_sub_serial #(.WIDTH(W)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_minuend    (a),
      .i_subtrahend (b),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_diff       (o_diff),
`ifdef CSKIPS_OVERFLOW_EN
      .o_borrow     (o_borrow),
      .o_overflow   (o_overflow)
`else
      .o_borrow     (o_borrow)
`endif
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Presents one operand pair and waits for o_valid; result is left un-consumed.
   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         output int lat, output bit got);
      lat = 0;
      got = 1'b0;
      for (int k = 0; k < 20 && !o_ready; k++) @(negedge clk);
      if (!o_ready) begin
         check("ready_timeout", {31'd0, o_ready}, 32'd1);
         return;
      end
      i_valid = 1'b1;
      a = va;
      b = vb;
      @(negedge clk);
      i_valid = 1'b0;
      a = 12'($urandom);
      b = 12'($urandom);
      for (int k = 0; k < 20 && !o_valid; k++) begin
         @(negedge clk);
         lat++;
      end
      got = o_valid;
      if (!got) check("valid_timeout", {31'd0, o_valid}, 32'd1);
   endtask

   task automatic consume();
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
   endtask

   initial begin
      int           lat;
      bit           got;
      logic [W-1:0] held;
      logic [W-1:0] q_d[$];
      logic         q_b[$];
      int           acc;
      int           cyc;

      vecs[0] = '{12'h005, 12'h003, 12'h002, 1'b0, 1'b0};
      vecs[1] = '{12'h000, 12'h001, 12'hFFF, 1'b1, 1'b0};
      vecs[2] = '{12'hABC, 12'hABC, 12'h000, 1'b0, 1'b0};
      vecs[3] = '{12'hFFF, 12'h000, 12'hFFF, 1'b0, 1'b0};
      vecs[4] = '{12'h000, 12'hFFF, 12'h001, 1'b1, 1'b0};
      vecs[5] = '{12'h123, 12'h456, 12'hCCD, 1'b1, 1'b0};
      vecs[6] = '{12'h800, 12'h001, 12'h7FF, 1'b0, 1'b1};
      vecs[7] = '{12'h7FF, 12'h800, 12'hFFF, 1'b1, 1'b1};
      vecs[8] = '{12'hF0F, 12'h0F0, 12'hE1F, 1'b0, 1'b0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_valid",  {31'd0, o_valid},  32'd0);
      check("rst_ready",  {31'd0, o_ready},  32'd1);
      check("rst_diff",   {20'd0, o_diff},   32'd0);
      check("rst_borrow", {31'd0, o_borrow}, 32'd0);
`ifdef CSKIPS_OVERFLOW_EN
      check("rst_ovf",    {31'd0, o_overflow}, 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors, each also checking the 3-edge latency
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, lat, got);
         if (got) begin
            check($sformatf("v%0d_lat", i),    lat,                      32'd3);
            check($sformatf("v%0d_diff", i),   {20'd0, o_diff},          {20'd0, vecs[i].diff});
            check($sformatf("v%0d_borrow", i), {31'd0, o_borrow},        {31'd0, vecs[i].borrow});
            check($sformatf("v%0d_ready", i),  {31'd0, o_ready},         32'd0);
`ifdef CSKIPS_OVERFLOW_EN
            check($sformatf("v%0d_ovf", i),    {31'd0, o_overflow},      {31'd0, vecs[i].ovf});
`endif
            consume();
         end
      end

      // Hold in DONE with i_ready low; new i_valid must be ignored
      run_op(12'h321, 12'h123, lat, got);
      held = 12'h1FE;
      for (int k = 0; k < 5; k++) begin
         i_valid = 1'b1;
         a = 12'($urandom);
         b = 12'($urandom);
         @(negedge clk);
         check("hold_valid", {31'd0, o_valid}, 32'd1);
         check("hold_diff",  {20'd0, o_diff},  {20'd0, held});
         check("hold_ready", {31'd0, o_ready}, 32'd0);
      end
      i_valid = 1'b0;
      consume();
      check("post_hold_ready", {31'd0, o_ready}, 32'd1);
      check("post_hold_valid", {31'd0, o_valid}, 32'd0);
      @(negedge clk);
      check("no_phantom_op", {31'd0, o_valid}, 32'd0);

      // Asynchronous reset in CALC with idx=1
      i_valid = 1'b1;
      a = 12'h123;
      b = 12'h456;
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_valid", {31'd0, o_valid}, 32'd0);
      check("abort_diff",  {20'd0, o_diff},  32'd0);
      check("abort_ready", {31'd0, o_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_no_result", {31'd0, o_valid}, 32'd0);
      run_op(12'h800, 12'h001, lat, got);
      if (got) begin
         check("after_rst_diff",   {20'd0, o_diff},   32'h7FF);
         check("after_rst_borrow", {31'd0, o_borrow}, 32'd0);
`ifdef CSKIPS_OVERFLOW_EN
         check("after_rst_ovf",    {31'd0, o_overflow}, 32'd1);
`endif
         consume();
      end

      // Random traffic against a reference queue
      acc = 0;
      cyc = 0;
      while ((acc < 1000 || q_d.size() > 0) && cyc < 40000) begin
         i_valid = (acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         a       = 12'($urandom);
         b       = 12'($urandom);
         i_ready = 1'($urandom_range(0, 1));
         if (i_valid && o_ready) begin
            q_d.push_back(a - b);
            q_b.push_back(a < b);
            acc++;
         end
         if (o_valid && i_ready) begin
            if (q_d.size() == 0) begin
               check("dup_result", {31'd0, o_valid}, 32'd0);
            end else begin
               check("rnd_diff",   {20'd0, o_diff},   {20'd0, q_d.pop_front()});
               check("rnd_borrow", {31'd0, o_borrow}, {31'd0, q_b.pop_front()});
            end
         end
         @(negedge clk);
         cyc++;
      end
      i_valid = 1'b0;
      i_ready = 1'b0;
      check("rnd_accepted", acc,        32'd1000);
      check("rnd_lost",     q_d.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
